id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX-side operand delivery for the 5-stage CPU; sits directly upstream of the ALU.

---
 rtl/id_ex_operand_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU-select decode, EX/MEM and MEM/WB operand
// forwarding, load-use stall detection and branch flush.
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [WIDTH-1:0] id_rs_data_i,
    input  logic [WIDTH-1:0] id_rt_data_i,
    input  logic [WIDTH-1:0] id_imm_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic [1:0]       id_aluop_i,
    input  logic [5:0]       id_funct_i,
    input  logic             id_alusrc_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             exmem_regwrite_i,
    input  logic [RA_W-1:0]  exmem_rd_i,
    input  logic [WIDTH-1:0] exmem_result_i,
    input  logic             memwb_regwrite_i,
    input  logic [RA_W-1:0]  memwb_rd_i,
    input  logic [WIDTH-1:0] memwb_result_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_sel_o,
    output logic [WIDTH-1:0] store_data_o,
    output logic [RA_W-1:0]  ex_rd_o,
    output logic             ex_valid_o,
    output logic             ex_regwrite_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             illegal_o
);

    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_SUB = 3'd1;
    localparam logic [2:0] SEL_AND = 3'd2;
    localparam logic [2:0] SEL_OR  = 3'd3;
    localparam logic [2:0] SEL_MUL = 3'd4;

    logic [WIDTH-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [RA_W-1:0]  ex_rs, ex_rt;
    logic             ex_alusrc;
    logic [2:0]       dec_sel;
    logic             dec_illegal;
    logic             load_bubble;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    always_comb begin
        dec_sel     = SEL_ADD;
        dec_illegal = 1'b0;
        case (id_aluop_i)
            2'b00:   dec_sel = SEL_ADD;
            2'b01:   dec_sel = SEL_SUB;
            2'b11:   dec_sel = SEL_OR;
            default: begin
                case (id_funct_i)
                    6'h20:   dec_sel = SEL_ADD;
                    6'h22:   dec_sel = SEL_SUB;
                    6'h24:   dec_sel = SEL_AND;
                    6'h25:   dec_sel = SEL_OR;
                    6'h18:   dec_sel = SEL_MUL;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // A load in EX cannot supply its data until MEM; hold ID one cycle if it needs it.
    assign stall_o = ex_valid_o && ex_memread_o && (ex_rd_o != '0) && id_valid_i &&
                     ((ex_rd_o == id_rs_i) || (ex_rd_o == id_rt_i));

    // ex_valid_o qualifies every EX output; bubbles carry valid=0 and no side-effecting controls.
    assign load_bubble = flush_i || stall_o || !id_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            illegal_o     <= 1'b0;
            alu_sel_o     <= SEL_ADD;
            ex_rd_o       <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_alusrc     <= 1'b0;
        end else if (load_bubble) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            illegal_o     <= 1'b0;
            ex_rd_o       <= '0;
        end else begin
            ex_valid_o    <= 1'b1;
            ex_regwrite_o <= id_regwrite_i && !dec_illegal;
            ex_memread_o  <= id_memread_i;
            ex_memwrite_o <= id_memwrite_i;
            illegal_o     <= dec_illegal;
            alu_sel_o     <= dec_sel;
            ex_rd_o       <= id_rd_i;
            ex_rs         <= id_rs_i;
            ex_rt         <= id_rt_i;
            ex_rs_data    <= id_rs_data_i;
            ex_rt_data    <= id_rt_data_i;
            ex_imm        <= id_imm_i;
            ex_alusrc     <= id_alusrc_i;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_rs = ex_rs_data;
        if ((ex_rs != '0) && exmem_regwrite_i && (exmem_rd_i == ex_rs))
            fwd_rs = exmem_result_i;
        else if ((ex_rs != '0) && memwb_regwrite_i && (memwb_rd_i == ex_rs))
            fwd_rs = memwb_result_i;
    end

    always_comb begin
        fwd_rt = ex_rt_data;
        if ((ex_rt != '0) && exmem_regwrite_i && (exmem_rd_i == ex_rt))
            fwd_rt = exmem_result_i;
        else if ((ex_rt != '0) && memwb_regwrite_i && (memwb_rd_i == ex_rt))
            fwd_rt = memwb_result_i;
    end

    assign alu_a_o      = fwd_rs;
    assign alu_b_o      = ex_alusrc ? ex_imm : fwd_rt;
    assign store_data_o = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized bench for id_ex_operand_stage against a
// behavioural model of the ID/EX latch, hazard and forwarding rules.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush_i, id_valid_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic [1:0]  id_aluop_i;
    logic [5:0]  id_funct_i;
    logic        id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic        stall_o;
    logic [31:0] alu_a_o, alu_b_o, store_data_o;
    logic [2:0]  alu_sel_o;
    logic [4:0]  ex_rd_o;
    logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, illegal_o;

    int tests = 0;
    int fails = 0;

    // Model of what the EX stage should hold.
    logic        m_valid, m_rw, m_mr, m_mw, m_ill, m_src;
    logic [2:0]  m_sel;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a, m_b, m_imm;

    id_ex_operand_stage #(.WIDTH(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_aluop_i(id_aluop_i), .id_funct_i(id_funct_i), .id_alusrc_i(id_alusrc_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .stall_o(stall_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_sel_o(alu_sel_o),
        .store_data_o(store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, sel} from the opcode table.
    function automatic logic [3:0] ref_decode(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'b00) return {1'b0, 3'd0};
        if (aluop == 2'b01) return {1'b0, 3'd1};
        if (aluop == 2'b11) return {1'b0, 3'd3};
        if (funct == 6'h20) return {1'b0, 3'd0};
        if (funct == 6'h22) return {1'b0, 3'd1};
        if (funct == 6'h24) return {1'b0, 3'd2};
        if (funct == 6'h25) return {1'b0, 3'd3};
        if (funct == 6'h18) return {1'b0, 3'd4};
        return {1'b1, 3'd0};
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (exmem_regwrite_i && exmem_rd_i == r) return exmem_result_i;
        if (memwb_regwrite_i && memwb_rd_i == r) return memwb_result_i;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0; m_src = 0;
        m_sel = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0;
    endtask

    task automatic clear_fwd();
        exmem_regwrite_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
        memwb_regwrite_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                             input logic [1:0] aluop, input logic [5:0] funct, input logic src,
                             input logic rw, input logic mr, input logic mw);
        id_valid_i = 1; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
        id_aluop_i = aluop; id_funct_i = funct; id_alusrc_i = src;
        id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw;
    endtask

    task automatic rand_inputs();
        logic [5:0] functs [6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h3F};
        id_valid_i    = ($urandom_range(0, 7) != 0);
        flush_i       = ($urandom_range(0, 7) == 0);
        id_rs_i       = 5'($urandom_range(0, 3));
        id_rt_i       = 5'($urandom_range(0, 3));
        id_rd_i       = 5'($urandom_range(0, 3));
        id_rs_data_i  = $urandom;
        id_rt_data_i  = $urandom;
        id_imm_i      = $urandom;
        id_aluop_i    = 2'($urandom_range(0, 3));
        id_funct_i    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
        id_alusrc_i   = 1'($urandom_range(0, 1));
        id_regwrite_i = 1'($urandom_range(0, 1));
        id_memread_i  = ($urandom_range(0, 2) == 0);
        id_memwrite_i = 1'($urandom_range(0, 1));
        exmem_regwrite_i = 1'($urandom_range(0, 1));
        exmem_rd_i       = 5'($urandom_range(0, 3));
        exmem_result_i   = $urandom;
        memwb_regwrite_i = 1'($urandom_range(0, 1));
        memwb_rd_i       = 5'($urandom_range(0, 3));
        memwb_result_i   = $urandom;
    endtask

    // Check current EX state at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        logic       exp_stall;
        logic [3:0] d;
        @(negedge clk);
        exp_stall = m_valid && m_mr && (m_rd != 0) && id_valid_i &&
                    ((m_rd == id_rs_i) || (m_rd == id_rt_i));
        chk("stall", 32'(stall_o), 32'(exp_stall));
        chk("ex_valid", 32'(ex_valid_o), 32'(m_valid));
        chk("ex_regwrite", 32'(ex_regwrite_o), 32'(m_rw));
        chk("ex_memread", 32'(ex_memread_o), 32'(m_mr));
        chk("ex_memwrite", 32'(ex_memwrite_o), 32'(m_mw));
        chk("illegal", 32'(illegal_o), 32'(m_ill));
        if (m_valid) begin
            chk("alu_sel", 32'(alu_sel_o), 32'(m_sel));
            chk("ex_rd", 32'(ex_rd_o), 32'(m_rd));
            chk("alu_a", alu_a_o, ref_fwd(m_rs, m_a));
            chk("alu_b", alu_b_o, m_src ? m_imm : ref_fwd(m_rt, m_b));
            chk("store_data", store_data_o, ref_fwd(m_rt, m_b));
        end
        @(posedge clk);
        if (flush_i || exp_stall || !id_valid_i) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0;
        end else begin
            d = ref_decode(id_aluop_i, id_funct_i);
            m_valid = 1; m_ill = d[3]; m_sel = d[2:0];
            m_rw = id_regwrite_i && !d[3]; m_mr = id_memread_i; m_mw = id_memwrite_i;
            m_rs = id_rs_i; m_rt = id_rt_i; m_rd = id_rd_i;
            m_a = id_rs_data_i; m_b = id_rt_data_i; m_imm = id_imm_i; m_src = id_alusrc_i;
        end
        #1;
    endtask

    initial begin
        rst_n = 0; flush_i = 0;
        set_instr(0, 0, 0, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0);
        id_valid_i = 0;
        clear_fwd();
        model_reset();
        @(posedge clk); #1;
        chk("rst_valid", 32'(ex_valid_o), 0);
        chk("rst_sel", 32'(alu_sel_o), 0);
        chk("rst_rd", 32'(ex_rd_o), 0);
        chk("rst_alu_a", alu_a_o, 0);
        chk("rst_alu_b", alu_b_o, 0);
        chk("rst_illegal", 32'(illegal_o), 0);
        rst_n = 1;

        // R-type add, then mul
        set_instr(8, 9, 10, 123, 456, 32'h11, 2'b10, 6'h20, 0, 1, 0, 0);
        cycle();
        chk("add_a", alu_a_o, 123);
        chk("add_b", alu_b_o, 456);
        chk("add_sel", 32'(alu_sel_o), 0);
        id_funct_i = 6'h18;
        cycle();
        chk("mul_sel", 32'(alu_sel_o), 4);

        // Forwarding priority and register-0 exclusion
        exmem_regwrite_i = 1; exmem_rd_i = 8; exmem_result_i = 7;
        memwb_regwrite_i = 1; memwb_rd_i = 8; memwb_result_i = 9;
        #1 chk("fwd_exmem_wins", alu_a_o, 7);
        exmem_rd_i = 0;
        #1 chk("fwd_memwb", alu_a_o, 9);
        memwb_regwrite_i = 0;
        #1 chk("fwd_rd0_none", alu_a_o, 123);
        clear_fwd();

        // Load-use: lw r8 followed by add using r8
        set_instr(1, 8, 8, 100, 0, 4, 2'b00, 6'h00, 1, 1, 1, 0);
        cycle();
        set_instr(8, 9, 10, 5, 6, 0, 2'b10, 6'h20, 0, 1, 0, 0);
        #1 chk("lu_stall", 32'(stall_o), 1);
        cycle();
        chk("lu_bubble", 32'(ex_valid_o), 0);
        chk("lu_stall_clear", 32'(stall_o), 0);
        cycle();
        chk("lu_issue_valid", 32'(ex_valid_o), 1);
        chk("lu_issue_rd", 32'(ex_rd_o), 10);

        // Flush in the same cycle as a stall
        set_instr(1, 8, 8, 100, 0, 4, 2'b00, 6'h00, 1, 1, 1, 0);
        cycle();
        set_instr(8, 9, 10, 5, 6, 0, 2'b10, 6'h20, 0, 1, 0, 0);
        flush_i = 1;
        #1 chk("flush_stall", 32'(stall_o), 1);
        cycle();
        chk("flush_bubble", 32'(ex_valid_o), 0);
        flush_i = 0;

        // Unsupported funct
        set_instr(3, 4, 5, 1, 2, 0, 2'b10, 6'h3F, 0, 1, 0, 0);
        cycle();
        chk("ill_sel", 32'(alu_sel_o), 0);
        chk("ill_flag", 32'(illegal_o), 1);
        chk("ill_regwrite", 32'(ex_regwrite_o), 0);

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset between edges
        clear_fwd(); flush_i = 0;
        set_instr(2, 3, 3, 32'hAA, 32'hBB, 32'hCC, 2'b10, 6'h25, 0, 1, 0, 1);
        cycle();
        #1 rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(ex_valid_o), 0);
        chk("mid_rst_ctrl", {28'd0, ex_regwrite_o, ex_memread_o, ex_memwrite_o, illegal_o}, 0);
        chk("mid_rst_sel", 32'(alu_sel_o), 0);
        chk("mid_rst_rd", 32'(ex_rd_o), 0);
        chk("mid_rst_a", alu_a_o, 0);
        chk("mid_rst_b", alu_b_o, 0);
        chk("mid_rst_store", store_data_o, 0);
        rst_n = 1;
        model_reset();

        for (int i = 0; i < 50; i++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
